// File: rtl/color_mask_gen.sv
// color_mask_gen: per-pixel RGB window classifier with regenerated AXI4-Stream framing.
// Define COLOR_MASK_STATS_EN to build the per-frame matched-pixel counter behind mask_count.
//
// state    | meaning
// WAIT_SOF | drop beats until a tuser beat starts a frame
// ACTIVE   | tracking x/y through the current frame
module color_mask_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic [23:0] thr_lo,
    input  logic [23:0] thr_hi,
    input  logic        enable,
    output logic        frame_done,
    output logic        sof_err,
    output logic        eol_err,
    output logic [19:0] mask_count
);
    typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    state_t      state, state_next;
    logic [10:0] x, y, px, py, x_next, y_next;
    logic        run, advance, accept, sof_beat, emit, line_end, frame_end;
    logic        sof_err_d, eol_err_d;
    logic [23:0] lo_s, hi_s, lo_e, hi_e, rgb;
    logic        en_s, en_e, match;
    logic        s1_valid, s1_match, s1_user, s1_last;
    logic [23:0] s1_rgb;
    logic        unused_hi;

    function automatic logic in_win(input logic [23:0] pix, input logic [23:0] lo,
                                    input logic [23:0] hi);
        in_win = (pix[23:16] >= lo[23:16]) && (pix[23:16] <= hi[23:16]) &&
                 (pix[15:8]  >= lo[15:8])  && (pix[15:8]  <= hi[15:8])  &&
                 (pix[7:0]   >= lo[7:0])   && (pix[7:0]   <= hi[7:0]);
    endfunction

    assign unused_hi     = ^s_axis_tdata[31:24];
    assign rgb           = s_axis_tdata[23:0];
    assign advance       = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = run && advance;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign sof_beat      = accept && s_axis_tuser;

    // An SOF beat is classified with the thresholds it latches, not the stale shadow copy.
    assign lo_e  = s_axis_tuser ? thr_lo : lo_s;
    assign hi_e  = s_axis_tuser ? thr_hi : hi_s;
    assign en_e  = s_axis_tuser ? enable : en_s;
    assign match = en_e && in_win(rgb, lo_e, hi_e);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= WAIT_SOF;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (sof_beat)            state_next = ACTIVE;
        if (emit && frame_end)   state_next = WAIT_SOF;
    end

    always_comb begin
        emit      = accept && (s_axis_tuser || (state == ACTIVE));
        px        = s_axis_tuser ? 11'd0 : x;
        py        = s_axis_tuser ? 11'd0 : y;
        line_end  = s_axis_tlast || (px == X_LAST);
        frame_end = line_end && (py == Y_LAST);
        sof_err_d = sof_beat && (state == ACTIVE) && ((x != 11'd0) || (y != 11'd0));
        eol_err_d = emit && (s_axis_tlast != (px == X_LAST));
        x_next    = x;
        y_next    = y;
        if (emit) begin
            if (frame_end) begin
                x_next = 11'd0;
                y_next = 11'd0;
            end else if (line_end) begin
                x_next = 11'd0;
                y_next = py + 11'd1;
            end else begin
                x_next = px + 11'd1;
                y_next = py;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run           <= 1'b0;
            x             <= '0;
            y             <= '0;
            lo_s          <= '0;
            hi_s          <= '0;
            en_s          <= 1'b0;
            frame_done    <= 1'b0;
            sof_err       <= 1'b0;
            eol_err       <= 1'b0;
            s1_valid      <= 1'b0;
            s1_match      <= 1'b0;
            s1_user       <= 1'b0;
            s1_last       <= 1'b0;
            s1_rgb        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            run        <= 1'b1;
            x          <= x_next;
            y          <= y_next;
            frame_done <= emit && frame_end;
            sof_err    <= sof_err_d;
            eol_err    <= eol_err_d;
            if (sof_beat) begin
                lo_s <= thr_lo;
                hi_s <= thr_hi;
                en_s <= enable;
            end
            if (advance) begin
                s1_valid      <= emit;
                s1_match      <= match;
                s1_user       <= (px == 11'd0) && (py == 11'd0);
                s1_last       <= (px == X_LAST);
                s1_rgb        <= rgb;
                m_axis_tvalid <= s1_valid;
                m_axis_tdata  <= {s1_match, 7'd0, s1_rgb};
                m_axis_tuser  <= s1_user;
                m_axis_tlast  <= s1_last;
            end
        end
    end

`ifdef COLOR_MASK_STATS_EN
    logic [19:0] cnt, cnt_next;

    always_comb begin
        cnt_next = sof_beat ? 20'd0 : cnt;
        if (emit && match && (cnt_next != 20'hFFFFF)) cnt_next = cnt_next + 20'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt        <= '0;
            mask_count <= '0;
        end else begin
            cnt <= cnt_next;
            if (emit && frame_end) mask_count <= cnt_next;
        end
    end
`else
    assign mask_count = '0;
`endif

endmodule
